// File: rtl/mole_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mole_pkg: shared types and constants for the whack-a-mole sequencer   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package mole_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PICK = 3'd1,
    UP   = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int          MOLE_COUNT = 16;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam int          CNT_W      = 8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mole_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mole_sequencer_if: control inputs and game-status outputs             |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface mole_sequencer_if;
  import mole_pkg::*;

  logic                  start_i;
  logic                  tick_i;
  logic                  whacked_i;
  logic [MOLE_COUNT-1:0] mole_o;
  logic [CNT_W-1:0]      score_o;
  logic [CNT_W-1:0]      misses_o;
  logic [CNT_W-1:0]      round_o;
  logic                  busy_o;
  logic                  done_o;

  modport master (
    output start_i, tick_i, whacked_i,
    input  mole_o, score_o, misses_o, round_o, busy_o, done_o
  );

  modport slave (
    input  start_i, tick_i, whacked_i,
    output mole_o, score_o, misses_o, round_o, busy_o, done_o
  );
endinterface
`default_nettype wire

// File: rtl/mole_lfsr.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mole_lfsr: free-running 16-bit Galois LFSR, right-shifting            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module mole_lfsr
  import mole_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock_i,
  input  logic        reset_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign lfsr_o = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/mole_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mole_sequencer: picks holes, times moles, scores hits/misses/rounds   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module mole_sequencer
  import mole_pkg::*;
#(
  parameter int          MOLE_TICKS = 50,
  parameter int          GAP_TICKS  = 10,
  parameter int          ROUNDS     = 30,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  mole_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0]      c_mole_ticks = CNT_W'(MOLE_TICKS);
  localparam logic [CNT_W-1:0]      c_gap_ticks  = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0]      c_rounds     = CNT_W'(ROUNDS);
  localparam logic [MOLE_COUNT-1:0] c_one        = {{(MOLE_COUNT-1){1'b0}}, 1'b1};

  state_t                r_state,    w_state_next;
  logic [CNT_W-1:0]      r_timer,    w_timer_next;
  logic [3:0]            r_last_idx, w_last_idx_next;
  logic [MOLE_COUNT-1:0] r_mole,     w_mole_next;
  logic [CNT_W-1:0]      r_score,    w_score_next;
  logic [CNT_W-1:0]      r_misses,   w_misses_next;
  logic [CNT_W-1:0]      r_round,    w_round_next;
  logic                  r_busy,     w_busy_next;
  logic                  r_done,     w_done_next;
  logic [15:0]           w_lfsr;
  logic [3:0]            w_pick_idx;

  mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .lfsr_o  (w_lfsr)
  );

  // Bump to the neighbouring hole so the same hole never shows twice in a row
  always_comb begin
    w_pick_idx = w_lfsr[3:0];
    if (w_pick_idx == r_last_idx) begin
      w_pick_idx = w_pick_idx + 4'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_last_idx <= '0;
      r_mole     <= '0;
      r_score    <= '0;
      r_misses   <= '0;
      r_round    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_timer    <= w_timer_next;
      r_last_idx <= w_last_idx_next;
      r_mole     <= w_mole_next;
      r_score    <= w_score_next;
      r_misses   <= w_misses_next;
      r_round    <= w_round_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_timer_next    = r_timer;
    w_last_idx_next = r_last_idx;
    w_mole_next     = r_mole;
    w_score_next    = r_score;
    w_misses_next   = r_misses;
    w_round_next    = r_round;

    unique case (r_state)
      IDLE, DONE: begin
        w_mole_next = '0;
        if (bus.start_i) begin
          w_score_next  = '0;
          w_misses_next = '0;
          w_round_next  = '0;
          w_state_next  = PICK;
        end
      end
      PICK: begin
        w_mole_next     = c_one << w_pick_idx;
        w_last_idx_next = w_pick_idx;
        w_round_next    = r_round + 1'b1;
        w_timer_next    = c_mole_ticks;
        w_state_next    = UP;
      end
      UP: begin
        // A hit outranks a timeout landing in the same cycle
        if (bus.whacked_i) begin
          w_score_next = sat_inc(r_score);
          w_mole_next  = '0;
          w_timer_next = c_gap_ticks;
          w_state_next = GAP;
        end else if (bus.tick_i) begin
          w_timer_next = r_timer - 1'b1;
          if (r_timer == 8'd1) begin
            w_misses_next = sat_inc(r_misses);
            w_mole_next   = '0;
            w_timer_next  = c_gap_ticks;
            w_state_next  = GAP;
          end
        end
      end
      GAP: begin
        w_mole_next = '0;
        if (bus.tick_i) begin
          w_timer_next = r_timer - 1'b1;
          if (r_timer == 8'd1) begin
            w_state_next = (r_round == c_rounds) ? DONE : PICK;
          end
        end
      end
      default: begin
        w_mole_next  = '0;
        w_state_next = IDLE;
      end
    endcase

    w_busy_next = (w_state_next == PICK) || (w_state_next == UP) || (w_state_next == GAP);
    w_done_next = (w_state_next == DONE);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      assert ($onehot0(r_mole));
    end
  end

  assign bus.mole_o   = r_mole;
  assign bus.score_o  = r_score;
  assign bus.misses_o = r_misses;
  assign bus.round_o  = r_round;
  assign bus.busy_o   = r_busy;
  assign bus.done_o   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mole_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mole_sequencer: directed checks of the whack-a-mole game sequencer |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_mole_sequencer;

  localparam int          ROUNDS_TB = 4;
  localparam logic [15:0] SEED_TB   = 16'hACE1;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  logic [15:0] m_lfsr;
  logic [3:0]  m_last;
  int          m_score, m_miss, m_round;

  mole_sequencer_if bus ();

  mole_sequencer #(
    .MOLE_TICKS (3),
    .GAP_TICKS  (2),
    .ROUNDS     (ROUNDS_TB),
    .LFSR_SEED  (SEED_TB)
  ) dut (
    .clock_i (clock),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSR kept in lockstep with the hardware one
  always @(posedge clock) m_lfsr <= reset ? SEED_TB : lfsr_next(m_lfsr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic t, input logic w);
    bus.start_i   = s;
    bus.tick_i    = t;
    bus.whacked_i = w;
    @(negedge clock);
    bus.start_i   = 1'b0;
    bus.tick_i    = 1'b0;
    bus.whacked_i = 1'b0;
  endtask

  task automatic tick4();
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 1, 0);
  endtask

  // Idle until the value the next PICK will see has the wanted low nibble
  task automatic steer(input int tgt);
    logic [15:0] p;
    logic [3:0]  want;
    int          k;
    if (tgt >= 0) begin
      want = tgt[3:0];
      p = lfsr_next(m_lfsr);
      k = 0;
      while (p[3:0] != want && k < 500) begin
        cyc(0, 0, 0);
        p = lfsr_next(m_lfsr);
        k++;
      end
      chk("steer_reach", {28'd0, p[3:0]}, {28'd0, want});
    end
  endtask

  // Called at the negedge inside the PICK cycle
  task automatic do_pick();
    logic [3:0]  idx;
    logic [15:0] prev_mask;
    logic [15:0] one;
    one       = 16'h0001;
    prev_mask = one << m_last;
    idx       = m_lfsr[3:0];
    if (idx == m_last) idx = idx + 4'd1;
    m_last = idx;
    m_round++;
    cyc(0, 0, 0);
    chk("pick_mask", {16'd0, bus.mole_o}, {16'd0, one << idx});
    chk("pick_distinct", {31'd0, bus.mole_o != prev_mask}, 32'd1);
    chk("pick_round", {24'd0, bus.round_o}, m_round);
    chk("pick_busy", {31'd0, bus.busy_o}, 32'd1);
  endtask

  task automatic start_game(input int tgt);
    steer(tgt);
    cyc(1, 0, 0);
    m_score = 0; m_miss = 0; m_round = 0;
    chk("start_done", {31'd0, bus.done_o}, 32'd0);
    chk("start_busy", {31'd0, bus.busy_o}, 32'd1);
    chk("start_score", {24'd0, bus.score_o}, 32'd0);
    chk("start_miss", {24'd0, bus.misses_o}, 32'd0);
    chk("start_round", {24'd0, bus.round_o}, 32'd0);
    do_pick();
  endtask

  // mode 0: miss, 1: whack one cycle after rise, 2: whack on the final tick
  task automatic run_round(input int mode, input int tgt);
    logic [15:0] up_mask;
    up_mask = bus.mole_o;
    if (mode == 1) begin
      cyc(0, 0, 1);
      m_score++;
      chk("hit_drop", {16'd0, bus.mole_o}, 32'd0);
    end else begin
      tick4(); tick4();
      chk("up_hold", {16'd0, bus.mole_o}, {16'd0, up_mask});
      cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
      cyc(0, 1, logic'(mode == 2));
      if (mode == 2) m_score++; else m_miss++;
      chk("up_drop", {16'd0, bus.mole_o}, 32'd0);
    end
    chk("round_score", {24'd0, bus.score_o}, m_score);
    chk("round_miss", {24'd0, bus.misses_o}, m_miss);
    cyc(0, 0, 1);
    chk("gap_whack_ignored", {24'd0, bus.score_o}, m_score);
    tick4();
    chk("gap_busy", {31'd0, bus.busy_o}, 32'd1);
    chk("gap_mole", {16'd0, bus.mole_o}, 32'd0);
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    steer(tgt);
    cyc(0, 1, 0);
    if (m_round == ROUNDS_TB) begin
      chk("end_done", {31'd0, bus.done_o}, 32'd1);
      chk("end_busy", {31'd0, bus.busy_o}, 32'd0);
    end else begin
      do_pick();
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_mole"}, {16'd0, bus.mole_o}, 32'd0);
    chk({tag, "_score"}, {24'd0, bus.score_o}, 32'd0);
    chk({tag, "_miss"}, {24'd0, bus.misses_o}, 32'd0);
    chk({tag, "_round"}, {24'd0, bus.round_o}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy_o}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done_o}, 32'd0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    m_last = '0; m_score = 0; m_miss = 0; m_round = 0;
    bus.start_i = 1'b0; bus.tick_i = 1'b0; bus.whacked_i = 1'b0;
    reset = 1'b1;
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    check_cleared("reset");

    // Idle with ticks: nothing may start on its own
    for (int i = 0; i < 5; i++) begin
      tick4();
      chk("idle_mole", {16'd0, bus.mole_o}, 32'd0);
      chk("idle_busy", {31'd0, bus.busy_o}, 32'd0);
    end
    check_cleared("idle");

    // Full miss game
    start_game(-1);
    for (int r = 0; r < ROUNDS_TB; r++) run_round(0, -1);
    chk("miss_game_miss", {24'd0, bus.misses_o}, 32'd4);
    chk("miss_game_score", {24'd0, bus.score_o}, 32'd0);
    chk("miss_game_round", {24'd0, bus.round_o}, 32'd4);

    // Full hit game, started from DONE
    start_game(-1);
    for (int r = 0; r < ROUNDS_TB; r++) run_round(1, -1);
    chk("hit_game_score", {24'd0, bus.score_o}, 32'd4);
    chk("hit_game_miss", {24'd0, bus.misses_o}, 32'd0);

    // Tie of hit and timeout, then steer round 3 to hole 8 and reset mid-UP
    start_game(-1);
    run_round(2, 3);
    chk("tie_score", {24'd0, bus.score_o}, 32'd1);
    chk("tie_miss", {24'd0, bus.misses_o}, 32'd0);
    run_round(1, 8);
    chk("pre_reset_mole", {16'd0, bus.mole_o}, 32'h0100);
    chk("pre_reset_score", {24'd0, bus.score_o}, 32'd2);
    cyc(1, 0, 0);
    chk("busy_start_round", {24'd0, bus.round_o}, 32'd3);
    chk("busy_start_mole", {16'd0, bus.mole_o}, 32'h0100);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_last = '0;
    check_cleared("mid_reset");
    cyc(0, 1, 1);
    check_cleared("post_reset");

    // Repeat avoidance: 0 after reset -> 1; 15 then 15 -> wraps to 0; 0 after 0 -> 1
    start_game(0);
    chk("rep_first", {16'd0, bus.mole_o}, 32'h0002);
    run_round(0, 15);
    chk("rep_fifteen", {16'd0, bus.mole_o}, 32'h8000);
    run_round(0, 15);
    chk("rep_wrap", {16'd0, bus.mole_o}, 32'h0001);
    run_round(0, 0);
    chk("rep_zero", {16'd0, bus.mole_o}, 32'h0002);
    run_round(0, -1);
    chk("rep_done_miss", {24'd0, bus.misses_o}, 32'd4);

    // Start from DONE clears counters and begins round 1
    start_game(-1);
    chk("restart_round", {24'd0, bus.round_o}, 32'd1);
    chk("restart_miss", {24'd0, bus.misses_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
